sigmoid_horner_dp: RTL

Datapath partner of the sigmoid coefficient controller. It receives the operand x and the stream of IEEE-754 single-precision polynomial coefficients, emitted constant-term first. It buffers the coefficients, then evaluates p(x) = c0 + c1·x + … + c(N-1)·x^(N-1) by Horner iteration, using one iterative fp32 multiplier and one fp32 adder. The result is delivered as a single-cycle valid pulse to the activation output stage.

---
 rtl/sigmoid_horner_dp.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sigmoid_horner_dp.sv
// sigmoid_horner_dp: buffers an fp32 coefficient set (c0 first), then evaluates
// p(x) by Horner iteration with one fp32 multiplier and one fp32 adder.
// Arithmetic: zero/denormal in -> signed zero, truncation rounding, saturation
// to +/-0x7F7FFFFF on exponent overflow, +0 on underflow or exact-zero sum.
// Optional build macro: SIG_CLAMP_EN clamps the registered result y to [0,1].
module sigmoid_horner_dp #(
    parameter int NCOEF = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] x_in,
    input  logic [31:0] cf,
    input  logic        cf_vld,
    output logic        cf_rdy,
    output logic [31:0] y,
    output logic        y_vld,
    output logic        busy
);
    localparam int IW = $clog2(NCOEF);
    localparam logic [IW-1:0] LAST_CNT = IW'(NCOEF - 1);
    localparam logic [IW-1:0] IDX_INIT = IW'(NCOEF - 2);

    typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_acc;
    logic [31:0]   r_prod;
    logic [31:0]   r_xr;
    logic [31:0]   r_y;
    logic          r_y_vld;
    logic [31:0]   r_buf [NCOEF];
    logic          w_accept;
    logic [31:0]   w_mul;
    logic [31:0]   w_sum;
    logic [31:0]   w_y_out;

    // fp32 multiply: 24x24 mantissa product, normalise by 0 or 1 bit, truncate.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [9:0]  esum;
        logic [22:0] m;
        logic [31:0] r;
        s    = a[31] ^ b[31];
        p    = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        m    = p[47] ? p[46:24] : p[45:23];
        // Biased exponent sum plus normalisation carry; bias removed below.
        esum = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, p[47]};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            r = {s, 31'd0};
        end else if (esum <= 10'd127) begin
            r = 32'd0;
        end else if (esum >= 10'd382) begin
            r = {s, 31'h7F7FFFFF};
        end else begin
            r = {s, 8'(esum - 10'd127), m};
        end
        return r;
    endfunction

    // fp32 add: order by magnitude, truncating alignment shift, 25-bit
    // add/subtract, leading-zero normalise.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_z;
        logic        b_z;
        logic [31:0] big;
        logic [31:0] sml;
        logic [7:0]  d;
        logic [23:0] mb;
        logic [23:0] ms;
        logic [24:0] sum;
        logic [23:0] diff;
        logic [23:0] norm;
        logic [4:0]  lz;
        logic        found;
        logic [8:0]  e9;
        logic [31:0] r;
        a_z   = (a[30:23] == 8'd0);
        b_z   = (b[30:23] == 8'd0);
        big   = (b[30:0] > a[30:0]) ? b : a;
        sml   = (b[30:0] > a[30:0]) ? a : b;
        d     = big[30:23] - sml[30:23];
        mb    = {1'b1, big[22:0]};
        ms    = (d > 8'd23) ? 24'd0 : ({1'b1, sml[22:0]} >> d);
        sum   = {1'b0, mb} + {1'b0, ms};
        diff  = mb - ms;
        lz    = 5'd0;
        found = 1'b0;
        for (int k = 23; k >= 0; k--) begin
            if (!found) begin
                if (diff[k]) found = 1'b1;
                else         lz = lz + 5'd1;
            end
        end
        norm  = diff << lz;
        r     = 32'd0;
        if (a_z && b_z) begin
            r = 32'd0;
        end else if (a_z) begin
            r = b;
        end else if (b_z) begin
            r = a;
        end else if (big[31] == sml[31]) begin
            e9 = {1'b0, big[30:23]} + {8'd0, sum[24]};
            if (e9 >= 9'd255) r = {big[31], 31'h7F7FFFFF};
            else              r = {big[31], e9[7:0], sum[24] ? sum[23:1] : sum[22:0]};
        end else if (diff == 24'd0) begin
            r = 32'd0;
        end else if ({1'b0, big[30:23]} <= {4'd0, lz}) begin
            r = 32'd0;
        end else begin
            r = {big[31], big[30:23] - {3'd0, lz}, norm[22:0]};
        end
        return r;
    endfunction

    assign w_accept = cf_vld && cf_rdy;
    assign w_mul    = fp_mul(r_acc, r_xr);
    assign w_sum    = fp_add(r_prod, r_buf[r_idx]);

`ifdef SIG_CLAMP_EN
    // Clamp the value presented on y to [0,1]; acc keeps the raw sum.
    always_comb begin
        w_y_out = w_sum;
        if (w_sum[31] && w_sum[30:0] != 31'd0)
            w_y_out = 32'h00000000;
        else if (!w_sum[31] && w_sum[30:0] > 31'h3F800000)
            w_y_out = 32'h3F800000;
    end
`else
    assign w_y_out = w_sum;
`endif

    // Next-state and state-decoded handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        cf_rdy       = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                cf_rdy = 1'b1;
                if (cf_vld && r_cnt == LAST_CNT) w_state_next = MUL;
            end
            MUL: begin
                busy         = 1'b1;
                w_state_next = ADD;
            end
            ADD: begin
                busy         = 1'b1;
                w_state_next = (r_idx == '0) ? IDLE : MUL;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Collection counter, operand latch and Horner accumulator/product registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_acc   <= 32'd0;
            r_prod  <= 32'd0;
            r_xr    <= 32'd0;
            r_y     <= 32'd0;
            r_y_vld <= 1'b0;
        end else begin
            r_y_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (r_cnt == '0) r_xr <= x_in;
                        if (r_cnt == LAST_CNT) begin
                            // Highest-degree coefficient seeds the accumulator directly.
                            r_acc <= cf;
                            r_idx <= IDX_INIT;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                MUL: r_prod <= w_mul;
                ADD: begin
                    r_acc <= w_sum;
                    if (r_idx == '0) begin
                        r_y     <= w_y_out;
                        r_y_vld <= 1'b1;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One register per coefficient slot, written when its index is collected.
    generate
        for (genvar gi = 0; gi < NCOEF; gi++) begin : g_buf
            always_ff @(posedge clk or posedge res) begin
                if (res)                                 r_buf[gi] <= 32'd0;
                else if (w_accept && r_cnt == IW'(gi))   r_buf[gi] <= cf;
            end
        end
    endgenerate

    assign y     = r_y;
    assign y_vld = r_y_vld;
endmodule
